// File: rtl/md_seq_unit_if.sv
// Handshake/data bundle between the pipeline and the multiply/divide unit.
interface md_seq_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [2:0]       md_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, md_op, a, b, input busy, done, hi, lo);
    modport slave  (input start, md_op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/md_seq_unit.sv
// MIPS HI/LO multiply/divide unit: single-cycle MULT/MTHI/MTLO, radix-2 restoring divider.
// Define MD_MAC_EN to enable MADD/MSUB; otherwise those opcodes are no-ops.
module md_seq_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input logic          clk,
    input logic          rst,
    md_seq_unit_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StDiv, StFix} state_e;

    localparam logic [2:0] OpMult  = 3'b000;
    localparam logic [2:0] OpMultu = 3'b001;
    localparam logic [2:0] OpDiv   = 3'b010;
    localparam logic [2:0] OpDivu  = 3'b011;
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;
`ifdef MD_MAC_EN
    localparam logic [2:0] OpMadd  = 3'b110;
    localparam logic [2:0] OpMsub  = 3'b111;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, a_q, a_d;
    logic             neg_q_q, neg_q_d, neg_r_q, neg_r_d, div0_q, div0_d;

    logic [2*WIDTH-1:0] prod_s, prod_u, acc;
    logic               a_neg, b_neg;
    logic [WIDTH:0]     rem_sh, diff;
    logic [WIDTH-1:0]   q_fix, r_fix;

    // Low 2*WIDTH bits of the sign-extended product equal the signed product.
    assign prod_s = {{WIDTH{bus.a[WIDTH-1]}}, bus.a} * {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
    assign prod_u = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};
    assign acc    = {hi_q, lo_q};

    assign a_neg = (bus.md_op == OpDiv) && bus.a[WIDTH-1];
    assign b_neg = (bus.md_op == OpDiv) && bus.b[WIDTH-1];

    // quo_q shifts the dividend out MSB-first while quotient bits shift in.
    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};
    assign q_fix  = neg_q_q ? -quo_q : quo_q;
    assign r_fix  = neg_r_q ? -rem_q : rem_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        a_d     = a_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        div0_d  = div0_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    case (bus.md_op)
                        OpMult: begin
                            {hi_d, lo_d} = prod_s;
                            done_d       = 1'b1;
                        end
                        OpMultu: begin
                            {hi_d, lo_d} = prod_u;
                            done_d       = 1'b1;
                        end
                        OpDiv, OpDivu: begin
                            quo_d   = a_neg ? -bus.a : bus.a;
                            dvs_d   = b_neg ? -bus.b : bus.b;
                            rem_d   = '0;
                            a_d     = bus.a;
                            neg_q_d = a_neg ^ b_neg;
                            neg_r_d = a_neg;
                            div0_d  = (bus.b == '0);
                            cnt_d   = '0;
                            state_d = StDiv;
                        end
                        OpMthi: begin
                            hi_d   = bus.a;
                            done_d = 1'b1;
                        end
                        OpMtlo: begin
                            lo_d   = bus.a;
                            done_d = 1'b1;
                        end
`ifdef MD_MAC_EN
                        OpMadd: begin
                            {hi_d, lo_d} = acc + prod_s;
                            done_d       = 1'b1;
                        end
                        OpMsub: begin
                            {hi_d, lo_d} = acc - prod_s;
                            done_d       = 1'b1;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            StDiv: begin
                if (!diff[WIDTH]) begin
                    rem_d = diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                // Divide-by-zero bypasses sign correction: lo=all ones, hi=dividend.
                if (div0_q) begin
                    hi_d = a_q;
                    lo_d = '1;
                end else begin
                    hi_d = r_fix;
                    lo_d = q_fix;
                end
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            a_q     <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            a_q     <= a_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            div0_q  <= div0_d;
        end
    end

    assign bus.busy = (state_q != StIdle);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
